// File: rtl/hb3_pkg.sv
// Shared types and defaults for the PmodHB3 H-bridge motor channel.
package hb3_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DEAD = 1'b1
   } state_e;

   localparam int SPEED_W             = 16;
   localparam int DEF_PWM_BITS        = 8;
   localparam int DEF_PRESCALE        = 100;
   localparam int DEF_DEADTIME_CYCLES = 100000;
   localparam int DEF_SAMPLE_CYCLES   = 1000000;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hb3_speed_meter.sv
// Hall-sensor speed meter: synchronises SA, counts rising edges per fixed window.
module hb3_speed_meter
   import hb3_pkg::*;
#(
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sa_in,
   output logic [SPEED_W-1:0] speed_count,
   output logic               speed_valid
);

   localparam int               WIN_W    = cnt_w(SAMPLE_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);

   logic               sa_meta;
   logic               sa_sync;
   logic               sa_sync_d;
   logic               rise;
   logic               win_end;
   logic [WIN_W-1:0]   win_cnt;
   logic [SPEED_W-1:0] edge_cnt;

   assign rise    = sa_sync & ~sa_sync_d;
   assign win_end = (win_cnt == WIN_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sa_meta     <= 1'b0;
         sa_sync     <= 1'b0;
         sa_sync_d   <= 1'b0;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         speed_count <= '0;
         speed_valid <= 1'b0;
      end else begin
         sa_meta     <= sa_in;
         sa_sync     <= sa_meta;
         sa_sync_d   <= sa_sync;
         speed_valid <= win_end;
         if (win_end) begin
            win_cnt     <= '0;
            speed_count <= edge_cnt;
            // An edge on the closing cycle belongs to the window that starts next.
            edge_cnt    <= rise ? SPEED_W'(1) : '0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            if (rise && (edge_cnt != '1))
               edge_cnt <= edge_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hb3_motor_channel.sv
// One PmodHB3 channel: PWM generation, dead time on direction reversal, speed measurement.
module hb3_motor_channel
   import hb3_pkg::*;
#(
   parameter int PWM_BITS        = DEF_PWM_BITS,
   parameter int PRESCALE        = DEF_PRESCALE,
   parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES,
   parameter int SAMPLE_CYCLES   = DEF_SAMPLE_CYCLES
) (
   input  logic                sys_clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [PWM_BITS-1:0] cmd_duty,
   input  logic                cmd_dir,
   output logic                pwm_out,
   output logic                dir_out,
   input  logic                sa_in,
   output logic [SPEED_W-1:0]  speed_count,
   output logic                speed_valid,
   output logic                busy
);

   localparam int                PRE_W     = cnt_w(PRESCALE);
   localparam int                DEAD_W    = cnt_w(DEADTIME_CYCLES);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

   state_e              state;
   state_e              state_nxt;
   logic [PRE_W-1:0]    presc_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_active;
   logic [PWM_BITS-1:0] duty_pend;
   logic                dir_pend;
   logic [DEAD_W-1:0]   dead_cnt;
   logic                tick;
   logic                wrap;
   logic                accept;
   logic                reverse;
   logic                dead_done;

   assign tick = (presc_cnt == PRE_LAST);
   assign wrap = tick && (pwm_cnt == '1);

   always_ff @(posedge sys_clock) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      reverse   = 1'b0;
      dead_done = 1'b0;
      case (state)
         RUN: begin
            cmd_ready = 1'b1;
            accept    = cmd_valid;
            reverse   = cmd_valid && (cmd_dir != dir_out);
            if (reverse) state_nxt = DEAD;
         end
         DEAD: begin
            busy      = 1'b1;
            dead_done = (dead_cnt == DEAD_LAST);
            if (dead_done) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         presc_cnt   <= '0;
         pwm_cnt     <= '0;
         duty_active <= '0;
         duty_pend   <= '0;
         dir_pend    <= 1'b0;
         dead_cnt    <= '0;
         dir_out     <= 1'b0;
         pwm_out     <= 1'b0;
      end else begin
         // Leaving DEAD restarts the PWM at the start of a fresh period.
         if (dead_done) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
         end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
         end

         if (accept) begin
            duty_pend <= cmd_duty;
            dir_pend  <= cmd_dir;
         end

         if (dead_done) begin
            dir_out     <= dir_pend;
            duty_active <= duty_pend;
         end else if ((state == RUN) && wrap) begin
            duty_active <= duty_pend;
         end

         if (reverse)            dead_cnt <= '0;
         else if (state == DEAD) dead_cnt <= dead_cnt + 1'b1;

         pwm_out <= (state == RUN) && !reverse && (pwm_cnt < duty_active);
      end
   end

   hb3_speed_meter #(
      .SAMPLE_CYCLES(SAMPLE_CYCLES)
   ) u_speed (
      .clk         (sys_clock),
      .reset       (reset),
      .sa_in       (sa_in),
      .speed_count (speed_count),
      .speed_valid (speed_valid)
   );

endmodule

// File: tb/tb_hb3_motor_channel.sv
// Directed bench for hb3_motor_channel with PRESCALE=2, PWM_BITS=4, dead time 8, window 64.
module tb_hb3_motor_channel;

   logic        sys_clock = 1'b0;
   logic        reset     = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_duty  = '0;
   logic        cmd_dir   = 1'b0;
   logic        pwm_out;
   logic        dir_out;
   logic        sa_in     = 1'b0;
   logic [15:0] speed_count;
   logic        speed_valid;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 sys_clock = ~sys_clock;

   hb3_motor_channel #(
      .PWM_BITS        (4),
      .PRESCALE        (2),
      .DEADTIME_CYCLES (8),
      .SAMPLE_CYCLES   (64)
   ) dut (
      .sys_clock   (sys_clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_duty    (cmd_duty),
      .cmd_dir     (cmd_dir),
      .pwm_out     (pwm_out),
      .dir_out     (dir_out),
      .sa_in       (sa_in),
      .speed_count (speed_count),
      .speed_valid (speed_valid),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic cycles(input int n, output int pwm_hi, output int dir_hi);
      pwm_hi = 0;
      dir_hi = 0;
      repeat (n) begin
         step();
         pwm_hi += int'(pwm_out);
         dir_hi += int'(dir_out);
      end
   endtask

   task automatic send(input logic [3:0] duty, input logic dir);
      cmd_valid = 1'b1;
      cmd_duty  = duty;
      cmd_dir   = dir;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rise(output bit ok);
      logic prev;
      ok   = 1'b0;
      prev = pwm_out;
      for (int i = 0; i < 80; i++) begin
         step();
         if (pwm_out && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = pwm_out;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ph, dh, ph2, dh2, n, rdy_lo, svh;
      bit ok;

      // Power-on reset
      repeat (3) step();
      reset = 1'b0;
      check("rst_pwm", pwm_out, 0);
      check("rst_dir", dir_out, 0);
      check("rst_speed", speed_count, 0);
      check("rst_valid", speed_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", cmd_ready, 1);

      // Duty 8, direction 0: 16 high of every 32 cycles
      send(4'd8, 1'b0);
      cycles(64, ph, dh);
      cycles(32, ph, dh);
      check("duty8_high", ph, 16);
      check("duty8_dir", dh, 0);

      // Reversal mid high phase
      wait_rise(ok);
      check("duty8_rise_seen", ok, 1);
      send(4'd8, 1'b1);
      check("rev_pwm_cut", pwm_out, 0);
      n = 0; rdy_lo = 0; ph = 0; dh = 0;
      while (busy && n < 20) begin
         n++;
         rdy_lo += int'(!cmd_ready);
         ph += int'(pwm_out);
         dh += int'(dir_out);
         step();
      end
      check("dead_cycles", n, 8);
      check("dead_ready_low", rdy_lo, 8);
      check("dead_pwm_high", ph, 0);
      check("dead_dir_early", dh, 0);
      check("dir_after_dead", dir_out, 1);
      check("pwm_at_exit", pwm_out, 0);
      step();
      check("pwm_restart", pwm_out, 1);
      cycles(15, ph, dh);
      check("restart_high_run", ph, 15);
      step();
      check("restart_first_low", pwm_out, 0);

      // Duty 0, duty 15, mid-period change to 4
      send(4'd0, 1'b1);
      check("same_dir_no_dead", busy, 0);
      cycles(64, ph, dh);
      cycles(32, ph, dh);
      check("duty0_high", ph, 0);
      send(4'd15, 1'b1);
      cycles(64, ph, dh);
      cycles(32, ph, dh);
      check("duty15_high", ph, 30);
      wait_rise(ok);
      check("duty15_rise_seen", ok, 1);
      send(4'd4, 1'b1);
      cycles(30, ph, dh);
      check("midper_old_duty", ph, 28);
      cycles(32, ph, dh);
      check("midper_new_duty", ph, 8);

      // Speed window: 5 edges, then one edge on the last cycle
      n = 0;
      while (!speed_valid && n < 200) begin
         step();
         n++;
      end
      check("win_found", speed_valid, 1);
      check("win_idle_count", speed_count, 0);
      svh = 0;
      for (int i = 0; i < 5; i++) begin
         sa_in = 1'b1; step(); svh += int'(speed_valid); step(); svh += int'(speed_valid);
         sa_in = 1'b0; step(); svh += int'(speed_valid); step(); svh += int'(speed_valid);
      end
      check("valid_pulse_width", svh, 0);
      repeat (41) step();
      sa_in = 1'b1;
      step();
      step();
      sa_in = 1'b0;
      step();
      check("win5_valid", speed_valid, 1);
      check("win5_count", speed_count, 5);
      n = 0;
      do begin
         step();
         n++;
      end while (!speed_valid && n < 100);
      check("win_length", n, 64);
      check("win_boundary_edge", speed_count, 1);

      // Reset mid-activity, with a reversal offered during reset
      cmd_valid = 1'b1; cmd_duty = 4'd9; cmd_dir = 1'b0;
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      cmd_valid = 1'b0;
      check("mrst_pwm", pwm_out, 0);
      check("mrst_dir", dir_out, 0);
      check("mrst_speed", speed_count, 0);
      check("mrst_valid", speed_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_ready", cmd_ready, 1);
      step();
      check("mrst_pwm_idle", pwm_out, 0);

      // Reset during DEAD
      send(4'd8, 1'b0);
      check("t6_same_dir", busy, 0);
      send(4'd8, 1'b1);
      check("t6_dead", busy, 1);
      cycles(3, ph, dh);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("drst_dir", dir_out, 0);
      check("drst_pwm", pwm_out, 0);
      check("drst_busy", busy, 0);
      check("drst_ready", cmd_ready, 1);
      send(4'd6, 1'b0);
      check("drst_accept_run", busy, 0);
      cycles(64, ph, dh);
      cycles(32, ph2, dh2);
      check("drst_duty6", ph2, 12);
      check("drst_dir_glitch", dh + dh2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
